// File: rtl/mic1_datapath_regs.sv
// MIC-1 register bank around the ALU/shifter: A/B bus drive, C-bus write-back,
// ALU flag latches and the registered memory read/write/fetch interface.
module mic1_datapath_regs #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] PC_RESET   = '0,
    parameter logic [DATA_WIDTH-1:0] SP_RESET   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] c_bus,
    input  logic [8:0]            c_enable,
    input  logic [3:0]            b_select,
    input  logic                  alu_n,
    input  logic                  alu_z,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  fetch,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic [7:0]            mem_fetch_data,
    output logic [DATA_WIDTH-1:0] a_bus,
    output logic [DATA_WIDTH-1:0] b_bus,
    output logic                  n_flag,
    output logic                  z_flag,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [DATA_WIDTH-1:0] fetch_addr,
    output logic                  fetch_en
);

    // Register indices follow the c_enable bit positions.
    localparam int NREG    = 9;
    localparam int IDX_MAR = 0;
    localparam int IDX_MDR = 1;
    localparam int IDX_PC  = 2;
    localparam int IDX_SP  = 3;
    localparam int IDX_LV  = 4;
    localparam int IDX_CPP = 5;
    localparam int IDX_TOS = 6;
    localparam int IDX_OPC = 7;
    localparam int IDX_H   = 8;

    logic [NREG-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [7:0]                      mbr_q, mbr_d;
    logic                            n_q, n_d, z_q, z_d;
    logic                            rd_en_q, rd_en_d, wr_en_q, wr_en_d, fetch_en_q, fetch_en_d;

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NREG; i++) begin
            if (c_enable[i]) begin
                regs_d[i] = c_bus;
            end
        end
        // A completing memory read takes MDR over any C-bus write in the same cycle.
        if (rd_en_q) begin
            regs_d[IDX_MDR] = mem_rdata;
        end
        mbr_d      = fetch_en_q ? mem_fetch_data : mbr_q;
        n_d        = alu_n;
        z_d        = alu_z;
        rd_en_d    = mem_read;
        wr_en_d    = mem_write;
        fetch_en_d = fetch;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q          <= '0;
            regs_q[IDX_PC]  <= PC_RESET;
            regs_q[IDX_SP]  <= SP_RESET;
            mbr_q           <= '0;
            n_q             <= 1'b0;
            z_q             <= 1'b0;
            rd_en_q         <= 1'b0;
            wr_en_q         <= 1'b0;
            fetch_en_q      <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            mbr_q      <= mbr_d;
            n_q        <= n_d;
            z_q        <= z_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            fetch_en_q <= fetch_en_d;
        end
    end

    always_comb begin
        b_bus = '0;
        case (b_select)
            4'd0:    b_bus = regs_q[IDX_MDR];
            4'd1:    b_bus = regs_q[IDX_PC];
            4'd2:    b_bus = {{(DATA_WIDTH-8){mbr_q[7]}}, mbr_q};
            4'd3:    b_bus = {{(DATA_WIDTH-8){1'b0}}, mbr_q};
            4'd4:    b_bus = regs_q[IDX_SP];
            4'd5:    b_bus = regs_q[IDX_LV];
            4'd6:    b_bus = regs_q[IDX_CPP];
            4'd7:    b_bus = regs_q[IDX_TOS];
            4'd8:    b_bus = regs_q[IDX_OPC];
            default: b_bus = '0;
        endcase
    end

    assign a_bus      = regs_q[IDX_H];
    assign n_flag     = n_q;
    assign z_flag     = z_q;
    assign mem_addr   = regs_q[IDX_MAR];
    assign mem_wdata  = regs_q[IDX_MDR];
    assign fetch_addr = regs_q[IDX_PC];
    assign mem_rd_en  = rd_en_q;
    assign mem_wr_en  = wr_en_q;
    assign fetch_en   = fetch_en_q;

endmodule
